// File: rtl/regfile_dump.sv
// regfile_dump: streams a window of an 8-entry register file out over a
// valid/ready handshake, one word per FETCH+SEND pair, then pulses done.
// The read port is purely combinational on the register file side, so
// readnum is registered here and data_out is sampled one cycle later.
// Optional feature: define REGFILE_DUMP_CSUM_EN to append a W-bit XOR
// checksum beat (out_idx = 7) after the last register beat.
module regfile_dump #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   first,
  input  logic [3:0]   count,
  output logic [2:0]   readnum,
  input  logic [W-1:0] data_out,
  output logic [W-1:0] out_data,
  output logic [2:0]   out_idx,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SEND  = 3'd2,
`ifdef REGFILE_DUMP_CSUM_EN
    S_CSUM  = 3'd3,
`endif
    S_DONE  = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic [2:0]     readnum_q, readnum_d;
  logic [W-1:0]   out_data_q, out_data_d;
  logic [2:0]     out_idx_q, out_idx_d;
  logic           out_valid_q, out_valid_d;
  logic [3:0]     rem_q, rem_d;
  logic [3:0]     count_clamped;
`ifdef REGFILE_DUMP_CSUM_EN
  logic [W-1:0]   csum_q, csum_d;
`endif

  // 0 and anything above 8 both mean "dump all eight registers".
  assign count_clamped = ((count == 4'd0) || (count > 4'd8)) ? 4'd8 : count;

  // Next-state and datapath decode for the dump sequencer.
  always_comb begin
    // NOTE: every signal assigned below gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    readnum_d   = readnum_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;
    rem_d       = rem_q;
`ifdef REGFILE_DUMP_CSUM_EN
    csum_d      = csum_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          readnum_d = first;
          rem_d     = count_clamped;
`ifdef REGFILE_DUMP_CSUM_EN
          csum_d    = '0;
`endif
          state_d   = S_FETCH;
        end
      end

      // Read data has had a full cycle to settle from the registered readnum.
      S_FETCH: begin
        out_data_d  = data_out;
        out_idx_d   = readnum_q;
        out_valid_d = 1'b1;
        state_d     = S_SEND;
      end

      // out_valid_q is always 1 here, so out_ready alone means acceptance.
      S_SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
`ifdef REGFILE_DUMP_CSUM_EN
          csum_d      = csum_q ^ out_data_q;
`endif
          if (rem_q > 4'd1) begin
            readnum_d = readnum_q + 3'd1;
            rem_d     = rem_q - 4'd1;
            state_d   = S_FETCH;
          end else begin
            rem_d     = 4'd0;
`ifdef REGFILE_DUMP_CSUM_EN
            state_d   = S_CSUM;
`else
            state_d   = S_DONE;
`endif
          end
        end
      end

`ifdef REGFILE_DUMP_CSUM_EN
      // First CSUM cycle loads the checksum beat, then it waits like SEND.
      S_CSUM: begin
        if (!out_valid_q) begin
          out_data_d  = csum_q;
          out_idx_d   = 3'd7;
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_DONE;
        end
      end
`endif

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples its pre-edge next value regardless of statement order.
    if (reset) begin
      state_q     <= S_IDLE;
      readnum_q   <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      rem_q       <= '0;
`ifdef REGFILE_DUMP_CSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      readnum_q   <= readnum_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
      rem_q       <= rem_d;
`ifdef REGFILE_DUMP_CSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign readnum   = readnum_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_regfile_dump.sv
// Testbench for regfile_dump: a register-file model drives data_out, and
// every dump is compared beat by beat against an expected list built from
// the window rules (wrap modulo 8, count clamping, optional XOR checksum).
module tb_regfile_dump;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   first;
  logic [3:0]   count;
  logic [2:0]   readnum;
  logic [W-1:0] data_out;
  logic [W-1:0] out_data;
  logic [2:0]   out_idx;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         done;

  logic [W-1:0] rf [0:7];

  int total = 0;
  int bad   = 0;

  regfile_dump #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .first     (first),
    .count     (count),
    .readnum   (readnum),
    .data_out  (data_out),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  assign data_out = rf[readnum];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // mode: 0 = ready always 1, 1 = random ready, 2 = 5-cycle stall on beat 2.
  // reset_beat >= 0 asserts reset while that beat is pending and ends the run.
  task automatic run_dump(input logic [2:0] f, input logic [3:0] c, input int mode,
                          input int reset_beat, input bit poke, input bit check_timing);
    int            n;
    int            got;
    int            stall;
    int            last_acc;
    bit            fin;
    logic [2:0]    idx;
    logic [W-1:0]  cs;
    logic [W-1:0]  ed[$];
    logic [2:0]    ei[$];
    logic          pv;
    logic          pacc;
    logic [W-1:0]  pd;
    logic [2:0]    pi;

    n = ((c == 4'd0) || (c > 4'd8)) ? 8 : int'(c);
    cs = '0;
    for (int k = 0; k < n; k++) begin
      idx = 3'((int'(f) + k) % 8);
      ei.push_back(idx);
      ed.push_back(rf[idx]);
      cs ^= rf[idx];
    end
`ifdef REGFILE_DUMP_CSUM_EN
    ei.push_back(3'd7);
    ed.push_back(cs);
`endif

    @(negedge clk);
    start = 1'b1; first = f; count = c; out_ready = 1'b0;
    got = 0; stall = 0; last_acc = 0; fin = 1'b0;
    pv = 1'b0; pacc = 1'b0; pd = '0; pi = '0;

    for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      first = 3'($urandom);
      count = 4'($urandom);
      if (poke && (cyc == 5)) start = 1'b1;

      if (pv && !pacc) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(pd));
        check("hold_idx", 32'(out_idx), 32'(pi));
      end

      if (done) begin
        check("beat_count", got, ei.size());
        check("done_valid", 32'(out_valid), 32'd0);
        if (check_timing) check("last_accept_cycle", last_acc, 16);
        start = 1'b1;  // start during DONE must be ignored
        fin = 1'b1;
      end else if (out_valid) begin
        if (reset_beat >= 0 && got == reset_beat) begin
          out_ready = 1'b1;  // reset must still win over ready
          reset = 1'b1;
          @(negedge clk);
          reset = 1'b0; out_ready = 1'b0;
          check("rst_valid", 32'(out_valid), 32'd0);
          check("rst_busy", 32'(busy), 32'd0);
          check("rst_readnum", 32'(readnum), 32'd0);
          check("rst_done", 32'(done), 32'd0);
          check("rst_data", 32'(out_data), 32'd0);
          check("rst_idx", 32'(out_idx), 32'd0);
          return;
        end
        case (mode)
          0: out_ready = 1'b1;
          1: out_ready = ($urandom_range(0, 3) != 0);
          default: begin
            if (got == 1 && stall < 5) begin
              out_ready = 1'b0;
              stall++;
            end else begin
              out_ready = 1'b1;
            end
          end
        endcase
        if (out_ready) begin
          if (got < ei.size()) begin
            check("beat_idx", 32'(out_idx), 32'(ei[got]));
            check("beat_data", 32'(out_data), 32'(ed[got]));
          end else begin
            check("extra_beat", got, ei.size());
          end
          got++;
          last_acc = cyc;
        end
      end else begin
        out_ready = 1'($urandom);
      end

      pv = out_valid; pacc = out_valid && out_ready; pd = out_data; pi = out_idx;
    end

    if (!fin) check("timeout", 0, 1);

    @(negedge clk);
    start = 1'b0; out_ready = 1'b0;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("idle_stays", 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; first = '0; count = '0; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) rf[i] = W'(16'h1000 + i);
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_readnum", 32'(readnum), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_data", 32'(out_data), 32'd0);
    reset = 1'b0;

`ifdef REGFILE_DUMP_CSUM_EN
    run_dump(3'd0, 4'd8, 0, -1, 1'b0, 1'b0);
`else
    run_dump(3'd0, 4'd8, 0, -1, 1'b0, 1'b1);
`endif
    run_dump(3'd6, 4'd4, 0, -1, 1'b0, 1'b0);
    run_dump(3'd2, 4'd0, 0, -1, 1'b0, 1'b0);
    run_dump(3'd5, 4'd12, 0, -1, 1'b0, 1'b0);
    run_dump(3'd0, 4'd8, 2, -1, 1'b0, 1'b0);
    run_dump(3'd0, 4'd8, 0, 2, 1'b0, 1'b0);
    run_dump(3'd0, 4'd8, 0, -1, 1'b0, 1'b0);

    rf[0] = 16'h000F; rf[1] = 16'h00F0; rf[2] = 16'h0F00; rf[3] = 16'hF000;
    run_dump(3'd0, 4'd4, 0, -1, 1'b1, 1'b0);

    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < 8; i++) rf[i] = W'($urandom);
      run_dump(3'($urandom), 4'($urandom), 1, -1, 1'($urandom), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
